// File: rtl/legup_mult_pkg.sv
// Shared constants and helpers for the pipelined multiplier companion blocks.
// Imported by legup_mult_result_fifo and legup_mult_result_buffer.
package legup_mult_pkg;

   localparam int LEGUP_MULT_MAX_PIPELINE = 16;
   localparam int LEGUP_MULT_MAX_DEPTH    = 64;
   localparam int LEGUP_MULT_OCC_W        = 7;

   // Pointer width that never collapses to zero bits for tiny depths.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/legup_mult_result_fifo.sv
// Synchronous FIFO with a registered head word; supports any DEPTH (pointers wrap modulo DEPTH).
// head_o keeps the last delivered word while the FIFO is empty.
module legup_mult_result_fifo
   import legup_mult_pkg::*;
#(
   parameter int WIDTHP = 64,
   parameter int DEPTH  = 4
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic                        push_i,
   input  logic [WIDTHP-1:0]           push_data_i,
   input  logic                        pop_i,
   output logic [WIDTHP-1:0]           head_o,
   output logic [LEGUP_MULT_OCC_W-1:0] count_o
);

   localparam int PTR_W = clog2_min1(DEPTH);

   logic [WIDTHP-1:0]           mem_q [DEPTH];
   logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
   logic [LEGUP_MULT_OCC_W-1:0] count_q, count_d;
   logic [WIDTHP-1:0]           head_q, head_d;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // The next head is either already stored or is the word being written this cycle.
      head_d = head_q;
      if (count_d != '0) begin
         head_d = (push_i && (wr_ptr_q == rd_ptr_d)) ? push_data_i : mem_q[rd_ptr_d];
      end
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         if (push_i) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/legup_mult_result_buffer.sv
// Valid/ready result buffer for a free-running, non-stallable multiplier; credits throttle issue.
// Optional same-cycle bypass of an empty FIFO: define LEGUP_MULT_RESULT_BYPASS_EN.
module legup_mult_result_buffer
   import legup_mult_pkg::*;
#(
   parameter int WIDTHP   = 64,
   parameter int PIPELINE = 3,
   parameter int DEPTH    = 4
) (
   input  logic                        clock_i,
   input  logic                        reset_i,
   input  logic                        issue_valid_i,
   output logic                        issue_ready_o,
   input  logic [WIDTHP-1:0]           mult_result_i,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [WIDTHP-1:0]           out_data_o,
   output logic [LEGUP_MULT_OCC_W-1:0] occupancy_o
);

   logic [PIPELINE-1:0]         vld_sr_q, vld_sr_d;
   logic [LEGUP_MULT_OCC_W-1:0] inflight_q, inflight_d;
   logic [LEGUP_MULT_OCC_W-1:0] fifo_count;
   logic [LEGUP_MULT_OCC_W-1:0] occ;
   logic [WIDTHP-1:0]           fifo_head;
   logic                        issue, mature, push, pop, fifo_empty;

   assign issue      = issue_valid_i && issue_ready_o;
   assign mature     = vld_sr_q[PIPELINE-1];
   assign fifo_empty = (fifo_count == '0);
   assign pop        = !fifo_empty && out_ready_i;

   // Credits come only from registered counts, so a pop frees its slot one cycle later.
   assign occ           = fifo_count + inflight_q;
   assign occupancy_o   = occ;
   assign issue_ready_o = !reset_i && (occ < LEGUP_MULT_OCC_W'(DEPTH));

`ifdef LEGUP_MULT_RESULT_BYPASS_EN
   logic byp;
   assign byp         = mature && fifo_empty;
   assign out_valid_o = !fifo_empty || byp;
   assign out_data_o  = byp ? mult_result_i : fifo_head;
   assign push        = mature && !(byp && out_ready_i);
`else
   assign out_valid_o = !fifo_empty;
   assign out_data_o  = fifo_head;
   assign push        = mature;
`endif

   always_comb begin
      vld_sr_d    = '0;
      vld_sr_d[0] = issue;
      for (int i = 1; i < PIPELINE; i++) vld_sr_d[i] = vld_sr_q[i-1];
      inflight_d = inflight_q;
      case ({issue, mature})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         vld_sr_q   <= '0;
         inflight_q <= '0;
      end else begin
         vld_sr_q   <= vld_sr_d;
         inflight_q <= inflight_d;
      end
   end

   legup_mult_result_fifo #(
      .WIDTHP (WIDTHP),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .push_i      (push),
      .push_data_i (mult_result_i),
      .pop_i       (pop),
      .head_o      (fifo_head),
      .count_o     (fifo_count)
   );

endmodule

// File: tb/tb_legup_mult_result_buffer.sv
// Bench: two buffer instances (P3/D4 and P2/D3) each fed by a behavioural pipelined multiplier.
module tb_legup_mult_result_buffer;

   localparam int PA = 3, DA = 4, PB = 2, DB = 3;
`ifdef LEGUP_MULT_RESULT_BYPASS_EN
   localparam int LAT_A = PA;
`else
   localparam int LAT_A = PA + 1;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic        iv_a = 0, ordy_a = 0, ir_a, ov_a;
   logic        iv_b = 0, ordy_b = 0, ir_b, ov_b;
   logic [31:0] opa_a = 0, opb_a = 0, opa_b = 0, opb_b = 0;
   logic [63:0] res_a, res_b, dat_a, dat_b;
   logic [6:0]  occ_a, occ_b;
   logic [63:0] pipe_a [PA];
   logic [63:0] pipe_b [PB];

   always @(posedge clock) begin
      pipe_a[0] <= {32'b0, opa_a} * {32'b0, opb_a};
      for (int i = 1; i < PA; i++) pipe_a[i] <= pipe_a[i-1];
      pipe_b[0] <= {32'b0, opa_b} * {32'b0, opb_b};
      for (int j = 1; j < PB; j++) pipe_b[j] <= pipe_b[j-1];
   end
   assign res_a = pipe_a[PA-1];
   assign res_b = pipe_b[PB-1];

   legup_mult_result_buffer #(.WIDTHP(64), .PIPELINE(PA), .DEPTH(DA)) u_a (
      .clock_i(clock), .reset_i(reset), .issue_valid_i(iv_a), .issue_ready_o(ir_a),
      .mult_result_i(res_a), .out_valid_o(ov_a), .out_ready_i(ordy_a),
      .out_data_o(dat_a), .occupancy_o(occ_a));

   legup_mult_result_buffer #(.WIDTHP(64), .PIPELINE(PB), .DEPTH(DB)) u_b (
      .clock_i(clock), .reset_i(reset), .issue_valid_i(iv_b), .issue_ready_o(ir_b),
      .mult_result_i(res_b), .out_valid_o(ov_b), .out_ready_i(ordy_b),
      .out_data_o(dat_b), .occupancy_o(occ_b));

   int n_checks = 0, n_errors = 0;
   int unsigned k_a = 0, k_b = 0;
   int n_iss_a = 0, n_pop_a = 0, n_iss_b = 0, n_pop_b = 0;
   logic [63:0] q_a[$], q_b[$];

   typedef struct {
      bit iv; bit ordy; bit exp_ir; int exp_occ; bit exp_ov_nb; bit exp_ov_byp; bit chk_d0;
   } vec_t;
   vec_t tbl[14];

   function automatic logic [63:0] prod(input int unsigned k);
      logic [63:0] a, b;
      a = 64'(k) * 64'd3;
      b = 64'(k) + 64'd1;
      return a * b;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after the negedge with inputs settled: score handshakes, advance one clock.
   task automatic cyc();
      bit iss_a, iss_b;
      iss_a = iv_a && ir_a;
      iss_b = iv_b && ir_b;
      if (iss_a) begin q_a.push_back(prod(k_a)); n_iss_a++; end
      if (iss_b) begin q_b.push_back(prod(k_b)); n_iss_b++; end
      if (ov_a && ordy_a) begin
         n_pop_a++;
         if (q_a.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_a_extra: got %0h expected no output", dat_a);
         end else chk("sb_a_data", dat_a, q_a.pop_front());
      end
      if (ov_b && ordy_b) begin
         n_pop_b++;
         if (q_b.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL sb_b_extra: got %0h expected no output", dat_b);
         end else chk("sb_b_data", dat_b, q_b.pop_front());
      end
      if (reset) begin q_a.delete(); q_b.delete(); end
      @(posedge clock);
      if (iss_a) k_a++;
      if (iss_b) k_b++;
      @(negedge clock);
      opa_a = 32'(k_a * 3); opb_a = 32'(k_a + 1);
      opa_b = 32'(k_b * 3); opb_b = 32'(k_b + 1);
   endtask

   task automatic drain(input string name);
      bit done;
      done = 0;
      iv_a = 0; iv_b = 0; ordy_a = 1; ordy_b = 1;
      for (int n = 0; n < 60 && !done; n++) begin
         #1;
         if (q_a.size() == 0 && q_b.size() == 0 && occ_a == 0 && occ_b == 0) done = 1;
         else cyc();
      end
      chk({name, "_drained"}, 64'(done), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first, pop0, iss0, pp_iss0, pp_pop0;
      int unsigned k0;
      bit prev_pop, prev_ir, exp_ov;

      //          iv ordy ir occ ov_nb ov_byp d0
      tbl[0]  = '{1, 0, 1, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 1, 1, 0, 0, 0};
      tbl[2]  = '{1, 0, 1, 2, 0, 0, 0};
      tbl[3]  = '{1, 0, 1, 3, 0, 1, 0};
      tbl[4]  = '{1, 0, 0, 4, 1, 1, 1};
      tbl[5]  = '{1, 0, 0, 4, 1, 1, 1};
      tbl[6]  = '{1, 0, 0, 4, 1, 1, 1};
      tbl[7]  = '{1, 0, 0, 4, 1, 1, 1};
      tbl[8]  = '{1, 0, 0, 4, 1, 1, 1};
      tbl[9]  = '{1, 1, 0, 4, 1, 1, 1};
      tbl[10] = '{1, 1, 1, 3, 1, 1, 0};
      tbl[11] = '{1, 1, 1, 3, 1, 1, 0};
      tbl[12] = '{0, 1, 1, 3, 1, 1, 0};
      tbl[13] = '{0, 1, 1, 2, 0, 1, 0};

      // Reset state
      repeat (2) @(negedge clock);
      #1;
      chk("rst_issue_ready", 64'(ir_a), 64'(0));
      chk("rst_out_valid", 64'(ov_a), 64'(0));
      chk("rst_out_data", dat_a, 64'(0));
      chk("rst_occupancy", 64'(occ_a), 64'(0));
      chk("rst_occupancy_b", 64'(occ_b), 64'(0));
      reset = 0;
      cyc();
      #1;
      chk("ready_after_reset", 64'(ir_a), 64'(1));

      // Streaming
      first = -1; pop0 = n_pop_a; iss0 = n_iss_a;
      ordy_a = 1;
      for (int r = 0; r < 200 && (n_pop_a - pop0) < 20; r++) begin
         iv_a = (n_iss_a - iss0) < 20;
         #1;
         if (ov_a && first < 0) first = r;
`ifdef LEGUP_MULT_RESULT_BYPASS_EN
         if (iv_a) chk("stream_ready", 64'(ir_a), 64'(1));
`endif
         chk("stream_occ_max", 64'(occ_a <= 7'd4), 64'(1));
         cyc();
      end
      chk("stream_first_valid", 64'(first), 64'(LAT_A));
      chk("stream_count", 64'(n_pop_a - pop0), 64'(20));
      drain("stream");

      // Back-pressure table
      k0 = k_a;
      for (int i = 0; i < 14; i++) begin
         iv_a = tbl[i].iv; ordy_a = tbl[i].ordy;
         #1;
`ifdef LEGUP_MULT_RESULT_BYPASS_EN
         exp_ov = tbl[i].exp_ov_byp;
`else
         exp_ov = tbl[i].exp_ov_nb;
`endif
         chk($sformatf("bp_ready[%0d]", i), 64'(ir_a), 64'(tbl[i].exp_ir));
         chk($sformatf("bp_occ[%0d]", i), 64'(occ_a), 64'(tbl[i].exp_occ));
         chk($sformatf("bp_valid[%0d]", i), 64'(ov_a), 64'(exp_ov));
         if (tbl[i].chk_d0) chk($sformatf("bp_hold_r0[%0d]", i), dat_a, prod(k0));
         cyc();
      end
      drain("bp");

      // Simultaneous push/pop around full
      pp_iss0 = n_iss_a; pp_pop0 = n_pop_a;
      iv_a = 1; ordy_a = 0;
      repeat (8) begin #1; cyc(); end
      #1;
      chk("pp_full_occ", 64'(occ_a), 64'(4));
      chk("pp_full_valid", 64'(ov_a), 64'(1));
      prev_pop = 0; prev_ir = 1;
      for (int r = 0; r < 16; r++) begin
         iv_a = 1; ordy_a = (r % 2 == 0);
         #1;
         chk("pp_occ_max", 64'(occ_a <= 7'd4), 64'(1));
         if (prev_pop && !prev_ir) chk("pp_ready_after_pop", 64'(ir_a), 64'(1));
         prev_pop = ov_a && ordy_a;
         prev_ir  = ir_a;
         cyc();
      end
      drain("pp");
      chk("pp_no_loss", 64'(n_pop_a - pp_pop0), 64'(n_iss_a - pp_iss0));

      // Reset mid-flight: two buffered, two in flight
      iv_a = 1; ordy_a = 0;
      repeat (5) begin #1; cyc(); end
      iv_a = 0;
      #1;
      chk("mid_occ", 64'(occ_a), 64'(4));
      chk("mid_valid", 64'(ov_a), 64'(1));
      reset = 1;
      #1;
      chk("mid_rst_ready", 64'(ir_a), 64'(0));
      cyc();
      reset = 0; ordy_a = 1;
      #1;
      chk("mid_rst_valid", 64'(ov_a), 64'(0));
      chk("mid_rst_occ", 64'(occ_a), 64'(0));
      for (int r = 0; r < 5; r++) begin
         #1;
         chk("mid_no_stale", 64'(ov_a), 64'(0));
         cyc();
      end

      // Random wrap-around on the DEPTH=3, PIPELINE=2 instance
      for (int r = 0; r < 100; r++) begin
         iv_b = 1'($urandom_range(0, 1));
         ordy_b = 1'($urandom_range(0, 1));
         #1;
         chk("rand_occ_max", 64'(occ_b <= 7'd3), 64'(1));
         cyc();
      end
      drain("rand");
      chk("rand_count", 64'(n_pop_b), 64'(n_iss_b));

      // Single-issue latency
      ordy_a = 1;
      for (int r = 0; r <= LAT_A + 1; r++) begin
         iv_a = (r == 0);
         #1;
         chk($sformatf("lat_valid[%0d]", r), 64'(ov_a), 64'(r == LAT_A));
         chk($sformatf("lat_occ[%0d]", r), 64'(occ_a), 64'(r >= 1 && r <= LAT_A));
         cyc();
      end
      #1;
      chk("lat_occ_after", 64'(occ_a), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
